// File: rtl/trace_prefetch_issuer_if.sv
// Bundle of the trace-repository, cache and retire signals of trace_prefetch_issuer.
// TRACE_PREFETCH_STATS_EN adds the issued/coalesced counter outputs.
interface trace_prefetch_issuer_if #(
    parameter int TRACKER_SLOTS   = 4,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int INDEX_WIDTH     = 16
);
    localparam int OCC_W = $clog2(TRACKER_SLOTS) + 1;

    logic                       entry_valid;
    logic [DATA_ADDR_WIDTH-1:0] entry_mem_addr;
    logic [INDEX_WIDTH-1:0]     entry_trace_index;
    logic                       entry_ready;
    logic                       req_valid;
    logic [DATA_ADDR_WIDTH-1:0] req_addr;
    logic                       req_ready;
    logic                       resp_valid;
    logic                       retire_valid;
    logic [INDEX_WIDTH-1:0]     retire_trace_index;
    logic                       retire_err;
    logic [OCC_W-1:0]           occupancy;
`ifdef TRACE_PREFETCH_STATS_EN
    logic [31:0]                issued_count;
    logic [31:0]                coalesced_count;
`endif

    modport master (
        output entry_valid, entry_mem_addr, entry_trace_index, req_ready, resp_valid,
               retire_valid, retire_trace_index,
        input  entry_ready, req_valid, req_addr, retire_err, occupancy
`ifdef TRACE_PREFETCH_STATS_EN
        , input issued_count, coalesced_count
`endif
    );

    modport slave (
        input  entry_valid, entry_mem_addr, entry_trace_index, req_ready, resp_valid,
               retire_valid, retire_trace_index,
        output entry_ready, req_valid, req_addr, retire_err, occupancy
`ifdef TRACE_PREFETCH_STATS_EN
        , output issued_count, coalesced_count
`endif
    );
endinterface

// File: rtl/trace_prefetch_issuer.sv
// Issues one cache prefetch per new trace address and tracks it until the processor retires it.
// Optional TRACE_PREFETCH_STATS_EN adds saturating issued/coalesced counters.
module trace_prefetch_issuer #(
    parameter int TRACKER_SLOTS   = 4,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int INDEX_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    trace_prefetch_issuer_if.slave bus
);
    localparam int SLOT_W = $clog2(TRACKER_SLOTS);
    localparam int OCC_W  = SLOT_W + 1;

    typedef enum logic [1:0] {
        MAKE_REQUEST,
        ISSUE,
        WAIT_FOR_PROCESSING,
        REQUEST_RETIRED
    } state_e;

    state_e                     state_q, state_d;
    logic [TRACKER_SLOTS-1:0]   occ_q, occ_d;
    logic [TRACKER_SLOTS-1:0]   proc_q, proc_d;
    logic [DATA_ADDR_WIDTH-1:0] addr_q [TRACKER_SLOTS];
    logic [INDEX_WIDTH-1:0]     idx_q  [TRACKER_SLOTS];
    logic [SLOT_W-1:0]          cur_q, cur_d;
    logic [DATA_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                       retire_err_q, retire_err_d;
    logic [OCC_W-1:0]           occupancy_q, occupancy_d;

    logic [TRACKER_SLOTS-1:0]   free_vec, match_vec, retire_vec;
    logic [SLOT_W-1:0]          alloc_slot, retire_slot;
    logic                       entry_ready_w, accept, alloc_en, issue_hs;

    genvar gi;
    generate
        for (gi = 0; gi < TRACKER_SLOTS; gi++) begin : g_slot
            assign free_vec[gi]   = ~occ_q[gi];
            assign match_vec[gi]  = occ_q[gi] && (addr_q[gi] == bus.entry_mem_addr);
            // Only slots whose prefetch has completed may be retired.
            assign retire_vec[gi] = occ_q[gi] && !proc_q[gi]
                                    && (idx_q[gi] == bus.retire_trace_index);
        end
    endgenerate

    // Descending scan so the lowest-numbered candidate wins.
    always_comb begin
        alloc_slot  = '0;
        retire_slot = '0;
        for (int i = TRACKER_SLOTS - 1; i >= 0; i--) begin
            if (free_vec[i])   alloc_slot  = SLOT_W'(i);
            if (retire_vec[i]) retire_slot = SLOT_W'(i);
        end
    end

    assign entry_ready_w = rst_n && (state_q == MAKE_REQUEST) && (|free_vec);
    assign accept        = entry_ready_w && bus.entry_valid;
    assign alloc_en      = accept && !(|match_vec);
    assign issue_hs      = (state_q == ISSUE) && bus.req_ready;

    always_comb begin
        state_d      = state_q;
        occ_d        = occ_q;
        proc_d       = proc_q;
        cur_d        = cur_q;
        req_addr_d   = req_addr_q;
        retire_err_d = 1'b0;
        occupancy_d  = '0;

        case (state_q)
            MAKE_REQUEST: begin
                if (alloc_en) begin
                    occ_d[alloc_slot]  = 1'b1;
                    proc_d[alloc_slot] = 1'b1;
                    cur_d              = alloc_slot;
                    req_addr_d         = bus.entry_mem_addr;
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_hs) state_d = WAIT_FOR_PROCESSING;
            end
            WAIT_FOR_PROCESSING: begin
                if (bus.resp_valid) begin
                    proc_d[cur_q] = 1'b0;
                    state_d       = REQUEST_RETIRED;
                end
            end
            REQUEST_RETIRED: state_d = MAKE_REQUEST;
            default:         state_d = MAKE_REQUEST;
        endcase

        // A retirable slot is never free, so it cannot collide with the allocation above.
        if (bus.retire_valid) begin
            if (|retire_vec) occ_d[retire_slot] = 1'b0;
            else             retire_err_d       = 1'b1;
        end

        for (int i = 0; i < TRACKER_SLOTS; i++) begin
            occupancy_d = occupancy_d + OCC_W'(occ_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= MAKE_REQUEST;
            occ_q        <= '0;
            proc_q       <= '0;
            cur_q        <= '0;
            req_addr_q   <= '0;
            retire_err_q <= 1'b0;
            occupancy_q  <= '0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            proc_q       <= proc_d;
            cur_q        <= cur_d;
            req_addr_q   <= req_addr_d;
            retire_err_q <= retire_err_d;
            occupancy_q  <= occupancy_d;
        end
    end

    // Slot payload is qualified by occ_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            addr_q[alloc_slot] <= bus.entry_mem_addr;
            idx_q[alloc_slot]  <= bus.entry_trace_index;
        end
    end

    assign bus.entry_ready = entry_ready_w;
    assign bus.req_valid   = (state_q == ISSUE);
    assign bus.req_addr    = req_addr_q;
    assign bus.retire_err  = retire_err_q;
    assign bus.occupancy   = occupancy_q;

`ifdef TRACE_PREFETCH_STATS_EN
    logic [31:0] issued_q, coalesced_q;
    logic        coalesce_hit;

    assign coalesce_hit = accept && (|match_vec);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued_q    <= '0;
            coalesced_q <= '0;
        end else begin
            if (issue_hs && (issued_q != '1))        issued_q    <= issued_q + 32'd1;
            if (coalesce_hit && (coalesced_q != '1)) coalesced_q <= coalesced_q + 32'd1;
        end
    end

    assign bus.issued_count    = issued_q;
    assign bus.coalesced_count = coalesced_q;
`endif
endmodule

// File: tb/tb_trace_prefetch_issuer.sv
// Directed bench for trace_prefetch_issuer: a slot-level reference model is checked every
// cycle, with hand-computed literal checks at scenario boundaries.
module tb_trace_prefetch_issuer;
    localparam int SLOTS = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    trace_prefetch_issuer_if #(.TRACKER_SLOTS(SLOTS), .DATA_ADDR_WIDTH(32), .INDEX_WIDTH(16)) bus ();

    trace_prefetch_issuer #(.TRACKER_SLOTS(SLOTS), .DATA_ADDR_WIDTH(32), .INDEX_WIDTH(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;
    int rv_seen    = 0;
    int err_seen   = 0;
    bit started    = 1'b0;

    // Reference model: slot table plus the phase of the one outstanding request
    // (0 idle, 1 request offered, 2 awaiting cache, 3 one-cycle completion gap).
    bit          m_occ  [SLOTS];
    bit          m_proc [SLOTS];
    logic [31:0] m_addr [SLOTS];
    logic [15:0] m_idx  [SLOTS];
    int          m_phase = 0;
    int          m_cur   = 0;
    logic [31:0] m_req_addr = '0;
    bit          m_err   = 1'b0;
    int          m_issued = 0;
    int          m_coal   = 0;

    function automatic int occ_count();
        int n = 0;
        for (int i = 0; i < SLOTS; i++) n += int'(m_occ[i]);
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int  ai;
        int  ri;
        bit  hit;
        bit  acc;
        if (!rst_n) begin
            started = 1'b1;
            for (int i = 0; i < SLOTS; i++) begin
                m_occ[i]  = 1'b0;
                m_proc[i] = 1'b0;
            end
            m_phase = 0; m_err = 1'b0; m_req_addr = '0; m_issued = 0; m_coal = 0;
        end else if (started) begin
            acc = (m_phase == 0) && bus.entry_valid && (occ_count() < SLOTS);
            hit = 1'b0;
            ai  = -1;
            ri  = -1;
            for (int i = 0; i < SLOTS; i++) begin
                if (m_occ[i] && m_addr[i] == bus.entry_mem_addr) hit = 1'b1;
                if (!m_occ[i] && ai < 0) ai = i;
                if (bus.retire_valid && m_occ[i] && !m_proc[i]
                    && m_idx[i] == bus.retire_trace_index && ri < 0) ri = i;
            end
            m_err = bus.retire_valid && (ri < 0);
            case (m_phase)
                1: if (bus.req_ready) begin m_phase = 2; m_issued++; end
                2: if (bus.resp_valid) begin m_proc[m_cur] = 1'b0; m_phase = 3; end
                3: m_phase = 0;
                default: ;
            endcase
            if (ri >= 0) m_occ[ri] = 1'b0;
            if (acc) begin
                if (hit) m_coal++;
                else begin
                    m_occ[ai]  = 1'b1;
                    m_proc[ai] = 1'b1;
                    m_addr[ai] = bus.entry_mem_addr;
                    m_idx[ai]  = bus.entry_trace_index;
                    m_cur      = ai;
                    m_req_addr = bus.entry_mem_addr;
                    m_phase    = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("entry_ready", 64'(bus.entry_ready), 64'(rst_n && m_phase == 0 && occ_count() < SLOTS));
            chk("req_valid", 64'(bus.req_valid), 64'(m_phase == 1));
            if (m_phase == 1) chk("req_addr", 64'(bus.req_addr), 64'(m_req_addr));
            chk("retire_err", 64'(bus.retire_err), 64'(m_err));
            chk("occupancy", 64'(bus.occupancy), 64'(occ_count()));
`ifdef TRACE_PREFETCH_STATS_EN
            chk("issued_count", 64'(bus.issued_count), 64'(m_issued));
            chk("coalesced_count", 64'(bus.coalesced_count), 64'(m_coal));
`endif
            if (bus.req_valid) rv_seen++;
            if (bus.retire_err) err_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] a, input logic [15:0] ix);
        bit ok = 1'b0;
        bus.entry_valid       = 1'b1;
        bus.entry_mem_addr    = a;
        bus.entry_trace_index = ix;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (bus.entry_ready) ok = 1'b1;
        end
        tick();
        bus.entry_valid = 1'b0;
        chk("offer_accepted_in_time", 64'(ok), 64'(1));
    endtask

    task automatic serve(input int hold, input int resp_wait);
        bus.req_ready = 1'b0;
        repeat (hold) tick();
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        repeat (resp_wait) tick();
        bus.resp_valid = 1'b1;
        tick();
        bus.resp_valid = 1'b0;
    endtask

    task automatic retire(input logic [15:0] ix);
        bus.retire_valid       = 1'b1;
        bus.retire_trace_index = ix;
        tick();
        bus.retire_valid = 1'b0;
    endtask

    initial begin
        rst_n                  = 1'b0;
        bus.entry_valid        = 1'b0;
        bus.entry_mem_addr     = '0;
        bus.entry_trace_index  = '0;
        bus.req_ready          = 1'b0;
        bus.resp_valid         = 1'b0;
        bus.retire_valid       = 1'b0;
        bus.retire_trace_index = '0;

        // Reset behaviour
        repeat (3) tick();
        chk("rst_entry_ready_low", 64'(bus.entry_ready), 64'(0));
        chk("rst_req_addr_zero", 64'(bus.req_addr), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("entry_ready_after_rst", 64'(bus.entry_ready), 64'(1));

        // Single request, cache responds three cycles after the handshake
        rv_seen = 0;
        offer(32'h1000, 16'd5);
        serve(0, 3);
        tick();
        chk("s034_req_valid_cycles", 64'(rv_seen), 64'(1));
        chk("s034_occupancy", 64'(bus.occupancy), 64'(1));
        chk("s034_back_to_accept", 64'(bus.entry_ready), 64'(1));

        // Same address again is coalesced
        rv_seen = 0;
        offer(32'h1000, 16'd6);
        tick();
        chk("s036_no_request", 64'(rv_seen), 64'(0));
        chk("s036_occupancy", 64'(bus.occupancy), 64'(1));
`ifdef TRACE_PREFETCH_STATS_EN
        chk("s036_coalesced", 64'(bus.coalesced_count), 64'(1));
`endif

        // Retire of a still-processing slot, then of an absent index
        err_seen = 0;
        offer(32'h2000, 16'd7);
        retire(16'd7);
        retire(16'd99);
        tick();
        serve(0, 0);
        chk("s037_err_pulses", 64'(err_seen), 64'(2));
        chk("s037_occupancy", 64'(bus.occupancy), 64'(2));
        retire(16'd5);
        retire(16'd7);
        chk("s037_drained", 64'(bus.occupancy), 64'(0));

        // Fill all slots, fifth offer blocked until a retire frees one
        for (int k = 0; k < 4; k++) begin
            offer(32'h100 * (k + 1), 16'(10 + k));
            serve(0, 0);
        end
        chk("s035_full_occupancy", 64'(bus.occupancy), 64'(4));
        bus.entry_valid       = 1'b1;
        bus.entry_mem_addr    = 32'h500;
        bus.entry_trace_index = 16'd14;
        tick();
        tick();
        chk("s035_full_not_ready", 64'(bus.entry_ready), 64'(0));
        retire(16'd11);
        chk("s039_ready_after_retire", 64'(bus.entry_ready), 64'(1));
        chk("s039_occupancy_3", 64'(bus.occupancy), 64'(3));
        tick();
        bus.entry_valid = 1'b0;
        chk("s039_accept_next_cycle", 64'(bus.occupancy), 64'(4));
        chk("s039_issue_started", 64'(bus.req_valid), 64'(1));
        serve(0, 0);

        // Stalled request, then reset mid-issue
        retire(16'd10);
        retire(16'd12);
        retire(16'd13);
        retire(16'd14);
        chk("s038_drained", 64'(bus.occupancy), 64'(0));
        offer(32'h3000, 16'd20);
        repeat (10) tick();
        chk("s038_req_addr_stable", 64'(bus.req_addr), 64'h3000);
        chk("s038_still_valid", 64'(bus.req_valid), 64'(1));
        rst_n = 1'b0;
        tick();
        chk("s038_rst_req_valid", 64'(bus.req_valid), 64'(0));
        chk("s038_rst_occupancy", 64'(bus.occupancy), 64'(0));
        chk("s038_rst_req_addr", 64'(bus.req_addr), 64'(0));
        rst_n = 1'b1;
        tick();
        chk("s038_ready_after_rst", 64'(bus.entry_ready), 64'(1));

        // Back-to-back allocations after reset
        offer(32'h4000, 16'd1);
        serve(0, 0);
        offer(32'h5000, 16'd2);
        serve(0, 0);
        tick();
        chk("final_occupancy", 64'(bus.occupancy), 64'(2));
`ifdef TRACE_PREFETCH_STATS_EN
        chk("final_issued", 64'(bus.issued_count), 64'(2));
`endif
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
